sample_scheduler: RTL and testbench
===================================

// Module: sample_scheduler
// PURPOSE
// Per-sample sequencer for the output datapath. Each sample_clk_en starts the operator pipeline.
// When the operators finish, it starts the channel accumulator. When accumulation latches, it
// emits sample_valid. Also supervises the frame: measures busy cycles, counts sample overruns,
// aborts hung frames on a timeout. Sits between the sample clock-enable generator and the
// operator/channel datapath.
// PARAMETERS
// TIMEOUT_CYCLES     256  busy-cycle limit per frame (one OPL3 sample period at 12.727 MHz)
// CYCLE_CNT_WIDTH    9    width of cycle counter and cycles_last; must hold TIMEOUT_CYCLES
// OVERRUN_CNT_WIDTH  8    width of overrun_count
// PORTS
// clk            in   1                  system clock; the only clock
// reset_n        in   1                  synchronous reset, active low
// sample_clk_en  in   1                  1-cycle pulse, start of new sample frame
// ops_done_pulse in   1                  operator pipeline finished all operators
// chan_done      in   1                  channel accumulator latched L/R result
// clear_status   in   1                  clears overrun_count and timeout_sticky
// ops_start      out  1                  1-cycle pulse, start operator pipeline
// chan_start     out  1                  1-cycle pulse, start channel accumulation
// abort          out  1                  1-cycle pulse, current frame abandoned
// sample_valid   out  1                  1-cycle pulse, frame completed normally
// busy           out  1                  high while state != IDLE
// cycles_last    out  CYCLE_CNT_WIDTH    busy cycles of last completed frame
// overrun_count  out  OVERRUN_CNT_WIDTH  saturating count of overruns
// timeout_sticky out  1                  set on timeout, held until clear_status
// BEHAVIOUR
// - Interface: one clock, clk; reset_n is synchronous and active low. All outputs are registered.
// - Reset (reset_n=0 at a clk edge): state=IDLE. All pulses, busy, cycles_last, overrun_count and
//   timeout_sticky are 0. Reset mid-frame drops the frame silently: no abort, no sample_valid.
// - FSM states: IDLE, OPS_WAIT, CHAN_WAIT, DONE.
//   IDLE: sample_clk_en -> OPS_WAIT; ops_start=1 and cnt=0 next cycle (latency 1).
//   OPS_WAIT: ops_done_pulse -> CHAN_WAIT; chan_start=1 next cycle.
//   CHAN_WAIT: chan_done -> DONE.
//   DONE: sample_valid=1 and cycles_last<=cnt for exactly this cycle, then -> IDLE.
// - cnt increments every cycle while state is OPS_WAIT or CHAN_WAIT, saturating at all-ones.
// - Timeout: in OPS_WAIT/CHAN_WAIT with cnt==TIMEOUT_CYCLES-1 and no advancing event:
//   abort=1, timeout_sticky<=1, -> IDLE. No sample_valid.
// - Overrun: sample_clk_en while state != IDLE: abort=1, overrun_count+1 (saturating).
//   The frame restarts: ops_start=1, cnt=0, -> OPS_WAIT.
//   Takes priority over ops_done_pulse/chan_done/timeout in the same cycle.
// - Priority per cycle: reset_n=0 > sample_clk_en > timeout > done inputs.
// - Ignored inputs: ops_done_pulse outside OPS_WAIT; chan_done outside CHAN_WAIT.
// - clear_status: clear first, then apply any same-cycle increment or set.
//   E.g. clear + overrun -> overrun_count=1; clear + timeout -> timeout_sticky=1.
// - ops_start, chan_start, abort and sample_valid are single-cycle pulses, never held.
// - busy: combinational decode of the registered state.
// TESTING
// 1 Normal frame: sample_clk_en@t0, ops_done_pulse@t0+40, chan_done@t0+80
//   -> ops_start@t0+1, chan_start@t0+41, sample_valid@t0+81, cycles_last=80, no abort.
// 2 Overrun: second sample_clk_en@t0+50 while in CHAN_WAIT -> abort and ops_start@t0+51,
//   overrun_count=1, no sample_valid. A following normal frame still completes.
// 3 Timeout: sample_clk_en, then no ops_done_pulse -> abort exactly TIMEOUT_CYCLES cycles
//   after ops_start, timeout_sticky=1, busy=0. clear_status -> timeout_sticky=0.
// 4 Simultaneous: chan_done and sample_clk_en in the same CHAN_WAIT cycle
//   -> overrun_count+1, restart, no sample_valid.
// 5 Reset mid-frame: reset_n=0 one cycle in OPS_WAIT -> all outputs 0 next cycle.
//   Stray ops_done_pulse/chan_done in IDLE -> no pulses.
// 6 Saturation: force 300 overruns with OVERRUN_CNT_WIDTH=8 -> overrun_count stays 255.
//   clear_status + overrun in the same cycle -> overrun_count=1.

Source files
------------

// File: rtl/sample_scheduler.sv
// Per-sample sequencer: kicks the operator pipeline, then the channel accumulator, and
// supervises each frame with a busy-cycle counter, overrun counting and a hang timeout.
module sample_scheduler #(
   parameter int TIMEOUT_CYCLES    = 256,
   parameter int CYCLE_CNT_WIDTH   = 9,
   parameter int OVERRUN_CNT_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sample_clk_en,
   input  logic                         ops_done_pulse,
   input  logic                         chan_done,
   input  logic                         clear_status,
   output logic                         ops_start,
   output logic                         chan_start,
   output logic                         abort,
   output logic                         sample_valid,
   output logic                         busy,
   output logic [CYCLE_CNT_WIDTH-1:0]   cycles_last,
   output logic [OVERRUN_CNT_WIDTH-1:0] overrun_count,
   output logic                         timeout_sticky
);

   typedef enum logic [1:0] {IDLE, OPS_WAIT, CHAN_WAIT, DONE} state_t;

   localparam logic [CYCLE_CNT_WIDTH-1:0] TIMEOUT_LAST = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                         state_q, state_d;
   logic [CYCLE_CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [CYCLE_CNT_WIDTH-1:0]     cycles_last_q, cycles_last_d;
   logic [OVERRUN_CNT_WIDTH-1:0]   overrun_count_q, overrun_count_d;
   logic                           timeout_sticky_q, timeout_sticky_d;
   logic                           ops_start_q, ops_start_d;
   logic                           chan_start_q, chan_start_d;
   logic                           abort_q, abort_d;
   logic                           sample_valid_q, sample_valid_d;
   logic                           waiting;
   logic                           overrun;
   logic                           timeout;

   // A frame that reaches the limit after a late ops_done (count already past it) still times out.
   always_comb begin
      waiting = (state_q == OPS_WAIT) || (state_q == CHAN_WAIT);
      overrun = sample_clk_en && (state_q != IDLE);
      timeout = waiting && !sample_clk_en && (cnt_q >= TIMEOUT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (sample_clk_en) begin
         state_d = OPS_WAIT;
      end else if (timeout) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            OPS_WAIT:  if (ops_done_pulse) state_d = CHAN_WAIT;
            CHAN_WAIT: if (chan_done)      state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = state_q;
         endcase
      end
   end

   // Counters take the clear first so a same-cycle increment or set still lands.
   always_comb begin
      ops_start_d    = sample_clk_en;
      chan_start_d   = (state_q == OPS_WAIT)  && (state_d == CHAN_WAIT);
      sample_valid_d = (state_q == CHAN_WAIT) && (state_d == DONE);
      abort_d        = overrun || timeout;

      cnt_d = cnt_q;
      if (sample_clk_en) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != '1)) begin
         cnt_d = cnt_q + CYCLE_CNT_WIDTH'(1);
      end

      cycles_last_d = cycles_last_q;
      if (sample_valid_d) begin
         cycles_last_d = cnt_d;
      end

      overrun_count_d = clear_status ? '0 : overrun_count_q;
      if (overrun && (overrun_count_d != '1)) begin
         overrun_count_d = overrun_count_d + OVERRUN_CNT_WIDTH'(1);
      end

      timeout_sticky_d = (timeout_sticky_q && !clear_status) || timeout;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q            <= '0;
         cycles_last_q    <= '0;
         overrun_count_q  <= '0;
         timeout_sticky_q <= 1'b0;
         ops_start_q      <= 1'b0;
         chan_start_q     <= 1'b0;
         abort_q          <= 1'b0;
         sample_valid_q   <= 1'b0;
      end else begin
         cnt_q            <= cnt_d;
         cycles_last_q    <= cycles_last_d;
         overrun_count_q  <= overrun_count_d;
         timeout_sticky_q <= timeout_sticky_d;
         ops_start_q      <= ops_start_d;
         chan_start_q     <= chan_start_d;
         abort_q          <= abort_d;
         sample_valid_q   <= sample_valid_d;
      end
   end

   always_comb begin
      ops_start      = ops_start_q;
      chan_start     = chan_start_q;
      abort          = abort_q;
      sample_valid   = sample_valid_q;
      busy           = (state_q != IDLE);
      cycles_last    = cycles_last_q;
      overrun_count  = overrun_count_q;
      timeout_sticky = timeout_sticky_q;
   end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: directed frame scenarios plus a randomized run checked
// against a frame-level model that tracks frame start times rather than a counter.
module tb_sample_scheduler;

   localparam int TIMEOUT = 256;

   logic       clk;
   logic       reset_n;
   logic       sample_clk_en;
   logic       ops_done_pulse;
   logic       chan_done;
   logic       clear_status;
   logic       ops_start;
   logic       chan_start;
   logic       abort;
   logic       sample_valid;
   logic       busy;
   logic [8:0] cycles_last;
   logic [7:0] overrun_count;
   logic       timeout_sticky;

   int tests_run = 0;
   int tests_failed = 0;

   sample_scheduler #(
      .TIMEOUT_CYCLES    (TIMEOUT),
      .CYCLE_CNT_WIDTH   (9),
      .OVERRUN_CNT_WIDTH (8)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_clk_en  (sample_clk_en),
      .ops_done_pulse (ops_done_pulse),
      .chan_done      (chan_done),
      .clear_status   (clear_status),
      .ops_start      (ops_start),
      .chan_start     (chan_start),
      .abort          (abort),
      .sample_valid   (sample_valid),
      .busy           (busy),
      .cycles_last    (cycles_last),
      .overrun_count  (overrun_count),
      .timeout_sticky (timeout_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame-level model: phase 0 idle, 1 waiting on operators, 2 waiting on channel, 3 done.
   int cyc = 0;
   int m_phase = 0;
   int m_start = 0;
   int m_last = 0;
   int m_ovr = 0;
   bit m_to = 0;
   bit m_ops = 0, m_chs = 0, m_ab = 0, m_sv = 0;

   task automatic model_step();
      int  elapsed;
      bit  in_wait;
      cyc++;
      elapsed = cyc - m_start;
      if (elapsed > 511) elapsed = 511;
      in_wait = (m_phase == 1) || (m_phase == 2);
      m_ops = 0; m_chs = 0; m_ab = 0; m_sv = 0;
      if (!reset_n) begin
         m_phase = 0; m_last = 0; m_ovr = 0; m_to = 0;
         return;
      end
      if (clear_status) begin
         m_ovr = 0; m_to = 0;
      end
      if (sample_clk_en) begin
         if (m_phase != 0) begin
            m_ab = 1;
            if (m_ovr < 255) m_ovr++;
         end
         m_ops = 1; m_start = cyc; m_phase = 1;
      end else if (in_wait && elapsed >= TIMEOUT) begin
         m_ab = 1; m_to = 1; m_phase = 0;
      end else if (m_phase == 1 && ops_done_pulse) begin
         m_chs = 1; m_phase = 2;
      end else if (m_phase == 2 && chan_done) begin
         m_sv = 1; m_last = elapsed; m_phase = 3;
      end else if (m_phase == 3) begin
         m_phase = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input bit s, input bit o, input bit c, input bit clr);
      sample_clk_en  = s;
      ops_done_pulse = o;
      chan_done      = c;
      clear_status   = clr;
   endtask

   task automatic test_reset();
      logic [22:0] got;
      reset_n = 1'b0;
      drive(0, 0, 0, 0);
      tick();
      tick();
      got = {ops_start, chan_start, abort, sample_valid, busy, cycles_last, overrun_count, timeout_sticky};
      tests_run++;
      if (got !== 23'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_state: got %h expected %h", got, 23'h0);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_normal_frame();
      logic [4:0] got, exp;
      int c;
      for (int k = 0; k <= 85; k++) begin
         drive(k == 0, k == 40, k == 80, 0);
         tick();
         c = k + 1;
         got = {ops_start, chan_start, abort, sample_valid, busy};
         exp = {c == 1, c == 41, 1'b0, c == 81, (c >= 1) && (c <= 81)};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL normal_frame cycle %0d: got %b expected %b", c, got, exp);
         end
         if (c == 81) begin
            tests_run++;
            if (cycles_last !== 9'd80) begin
               tests_failed++;
               $display("[TB] FAIL normal_cycles_last: got %0d expected 80", cycles_last);
            end
         end
      end
      tests_run++;
      if ({overrun_count, timeout_sticky} !== 9'h0) begin
         tests_failed++;
         $display("[TB] FAIL normal_status: got %h expected 0", {overrun_count, timeout_sticky});
      end
   endtask

   task automatic test_overrun();
      logic [4:0] got, exp;
      int c;
      for (int k = 0; k <= 75; k++) begin
         drive(k == 0 || k == 50, k == 20 || k == 60, k == 70, 0);
         tick();
         c = k + 1;
         got = {ops_start, chan_start, abort, sample_valid, busy};
         exp = {c == 1 || c == 51, c == 21 || c == 61, c == 51, c == 71, (c >= 1) && (c <= 71)};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL overrun cycle %0d: got %b expected %b", c, got, exp);
         end
         if (c == 71) begin
            tests_run++;
            if (cycles_last !== 9'd20) begin
               tests_failed++;
               $display("[TB] FAIL overrun_cycles_last: got %0d expected 20", cycles_last);
            end
         end
      end
      tests_run++;
      if (overrun_count !== 8'd1) begin
         tests_failed++;
         $display("[TB] FAIL overrun_count: got %0d expected 1", overrun_count);
      end
   endtask

   task automatic test_timeout();
      logic [4:0] got, exp;
      int c;
      for (int k = 0; k <= 259; k++) begin
         drive(k == 0, 0, 0, 0);
         tick();
         c = k + 1;
         got = {ops_start, chan_start, abort, sample_valid, busy};
         exp = {c == 1, 1'b0, c == TIMEOUT + 1, 1'b0, (c >= 1) && (c <= TIMEOUT)};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL timeout cycle %0d: got %b expected %b", c, got, exp);
         end
      end
      tests_run++;
      if ({timeout_sticky, busy, cycles_last} !== {1'b1, 1'b0, 9'd20}) begin
         tests_failed++;
         $display("[TB] FAIL timeout_status: got %h expected %h", {timeout_sticky, busy, cycles_last},
                  {1'b1, 1'b0, 9'd20});
      end
      drive(0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      tests_run++;
      if ({timeout_sticky, overrun_count} !== 9'h0) begin
         tests_failed++;
         $display("[TB] FAIL clear_status: got %h expected 0", {timeout_sticky, overrun_count});
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] got, exp;
      int c;
      for (int k = 0; k <= 23; k++) begin
         drive(k == 0 || k == 10, k == 5 || k == 15, k == 10 || k == 20, 0);
         tick();
         c = k + 1;
         got = {ops_start, chan_start, abort, sample_valid, busy};
         exp = {c == 1 || c == 11, c == 6 || c == 16, c == 11, c == 21, (c >= 1) && (c <= 21)};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL simultaneous cycle %0d: got %b expected %b", c, got, exp);
         end
      end
      tests_run++;
      if ({overrun_count, cycles_last} !== {8'd1, 9'd10}) begin
         tests_failed++;
         $display("[TB] FAIL simultaneous_status: got %h expected %h", {overrun_count, cycles_last},
                  {8'd1, 9'd10});
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [22:0] got;
      logic [4:0]  pulses;
      for (int k = 0; k <= 4; k++) begin
         drive(k == 0, 0, 0, 0);
         tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      got = {ops_start, chan_start, abort, sample_valid, busy, cycles_last, overrun_count, timeout_sticky};
      tests_run++;
      if (got !== 23'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_mid_frame: got %h expected 0", got);
      end
      for (int k = 6; k <= 10; k++) begin
         drive(0, k == 6 || k == 8, k == 7 || k == 8, 0);
         tick();
         pulses = {ops_start, chan_start, abort, sample_valid, busy};
         tests_run++;
         if (pulses !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL stray_inputs step %0d: got %b expected 00000", k, pulses);
         end
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k <= 300; k++) begin
         drive(1, 0, 0, 0);
         tick();
         if (k > 0) begin
            tests_run++;
            if (abort !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL saturation_abort step %0d: got %b expected 1", k, abort);
            end
         end
      end
      tests_run++;
      if (overrun_count !== 8'd255) begin
         tests_failed++;
         $display("[TB] FAIL overrun_saturate: got %0d expected 255", overrun_count);
      end
      drive(1, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      tests_run++;
      if (overrun_count !== 8'd1) begin
         tests_failed++;
         $display("[TB] FAIL clear_plus_overrun: got %0d expected 1", overrun_count);
      end
   endtask

   task automatic test_random();
      logic [22:0] got, exp;
      int done_rate, smp_rate;
      done_rate = 8;
      smp_rate = 100;
      for (int k = 0; k < 3000; k++) begin
         if (k % 500 == 0) begin
            case ($urandom_range(0, 2))
               0:       done_rate = 2;
               1:       done_rate = 8;
               default: done_rate = 400;
            endcase
            smp_rate = $urandom_range(30, 400);
         end
         reset_n = ($urandom_range(0, 299) != 0);
         drive($urandom_range(0, smp_rate - 1) == 0, $urandom_range(0, done_rate - 1) == 0,
               $urandom_range(0, done_rate - 1) == 0, $urandom_range(0, 39) == 0);
         tick();
         got = {ops_start, chan_start, abort, sample_valid, busy, cycles_last, overrun_count, timeout_sticky};
         exp = {m_ops, m_chs, m_ab, m_sv, m_phase != 0, 9'(m_last), 8'(m_ovr), m_to};
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL random cycle %0d: got %h expected %h", k, got, exp);
         end
      end
      reset_n = 1'b1;
      drive(0, 0, 0, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0);
      test_reset();
      test_normal_frame();
      test_overrun();
      test_timeout();
      test_simultaneous();
      test_reset_mid_frame();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
